ps2_keyboard: RTL and testbench



---
 rtl/ps2_keyboard_pkg.sv | 20 ++
 rtl/ps2_keyboard_seg7_hex.sv | 38 +++
 rtl/ps2_keyboard.sv | 148 ++++++++++++++
 tb/tb_ps2_keyboard.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/ps2_keyboard_pkg.sv
// Shared PS/2 receiver constants, receive FSM state encodings and the frame parity helper.
package ps2_keyboard_pkg;

   localparam logic [7:0] BREAK_CODE = 8'hF0;
   localparam logic [7:0] EXT_CODE   = 8'hE0;
   localparam logic [6:0] SEG_BLANK  = 7'h7F;

   typedef logic [1:0] rx_state_t;

   localparam rx_state_t ST_IDLE   = 2'd0;
   localparam rx_state_t ST_DATA   = 2'd1;
   localparam rx_state_t ST_PARITY = 2'd2;
   localparam rx_state_t ST_STOP   = 2'd3;

   // PS/2 frames use odd parity over the eight data bits plus the parity bit.
   function automatic logic odd_parity_ok(input logic [7:0] data, input logic parity);
      return ^{data, parity};
   endfunction

endpackage

// File: rtl/ps2_keyboard_seg7_hex.sv
// Hex digit to active-low seven-segment decoder {g,f,e,d,c,b,a}; blank when disabled.
module seg7_hex
   import ps2_keyboard_pkg::*;
(
   input  logic [3:0] value,
   input  logic       en,
   output logic [6:0] seg
);

   // Decode one nibble, forcing all segments off until the display is enabled.
   always_comb begin
      seg = SEG_BLANK;
      if (en) begin
         case (value)
            4'h0:    seg = 7'h40;
            4'h1:    seg = 7'h79;
            4'h2:    seg = 7'h24;
            4'h3:    seg = 7'h30;
            4'h4:    seg = 7'h19;
            4'h5:    seg = 7'h12;
            4'h6:    seg = 7'h02;
            4'h7:    seg = 7'h78;
            4'h8:    seg = 7'h00;
            4'h9:    seg = 7'h10;
            4'hA:    seg = 7'h08;
            4'hB:    seg = 7'h03;
            4'hC:    seg = 7'h46;
            4'hD:    seg = 7'h21;
            4'hE:    seg = 7'h06;
            4'hF:    seg = 7'h0E;
            default: seg = SEG_BLANK;
         endcase
      end else begin
         seg = SEG_BLANK;
      end
   end

endmodule

// File: rtl/ps2_keyboard.sv
// PS/2 keyboard receiver: deframes device-to-host bytes, tracks make/break state,
// counts key presses and shows the last byte on two seven-segment digits.
module ps2_keyboard
   import ps2_keyboard_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 100000,
   parameter int CNT_W          = 16
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             ps2_clk,
   input  logic             ps2_data,
   output logic [7:0]       code,
   output logic             code_valid,
   output logic             frame_err,
   output logic [7:0]       key_code,
   output logic             key_down,
   output logic [CNT_W-1:0] press_cnt,
   output logic [6:0]       seg_lo,
   output logic [6:0]       seg_hi
);

   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

   logic [1:0]       ps2_clk_sync_r;
   logic [1:0]       ps2_data_sync_r;
   logic             ps2_clk_prev_r;
   logic             fall_s;
   logic             bit_s;

   rx_state_t        state_r;
   logic [2:0]       bit_cnt_r;
   logic [7:0]       shift_r;
   logic             parity_r;
   logic [TW-1:0]    tmo_cnt_r;
   logic             break_r;
   logic             disp_en_r;
   logic [7:0]       code_r;
   logic             code_valid_r;
   logic             frame_err_r;
   logic [7:0]       key_code_r;
   logic             key_down_r;
   logic [CNT_W-1:0] press_cnt_r;

   // Two-flop synchronisers plus the previous clock sample for edge detection.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         ps2_clk_sync_r  <= 2'b11;
         ps2_data_sync_r <= 2'b11;
         ps2_clk_prev_r  <= 1'b1;
      end else begin
         ps2_clk_sync_r  <= {ps2_clk_sync_r[0], ps2_clk};
         ps2_data_sync_r <= {ps2_data_sync_r[0], ps2_data};
         ps2_clk_prev_r  <= ps2_clk_sync_r[1];
      end
   end

   assign fall_s = ps2_clk_prev_r & ~ps2_clk_sync_r[1];
   assign bit_s  = ps2_data_sync_r[1];

   // Receive FSM, inactivity timeout and make/break key tracking.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_r      <= ST_IDLE;
         bit_cnt_r    <= 3'd0;
         shift_r      <= 8'h00;
         parity_r     <= 1'b0;
         tmo_cnt_r    <= '0;
         break_r      <= 1'b0;
         disp_en_r    <= 1'b0;
         code_r       <= 8'h00;
         code_valid_r <= 1'b0;
         frame_err_r  <= 1'b0;
         key_code_r   <= 8'h00;
         key_down_r   <= 1'b0;
         press_cnt_r  <= '0;
      end else begin
         code_valid_r <= 1'b0;
         frame_err_r  <= 1'b0;
         if (state_r == ST_IDLE) begin
            tmo_cnt_r <= '0;
            if (fall_s && !bit_s) begin
               state_r   <= ST_DATA;
               bit_cnt_r <= 3'd0;
            end
         end else if (fall_s) begin
            tmo_cnt_r <= '0;
            case (state_r)
               ST_DATA: begin
                  shift_r   <= {bit_s, shift_r[7:1]};
                  bit_cnt_r <= bit_cnt_r + 3'd1;
                  if (bit_cnt_r == 3'd7) begin
                     state_r <= ST_PARITY;
                  end
               end
               ST_PARITY: begin
                  parity_r <= bit_s;
                  state_r  <= ST_STOP;
               end
               ST_STOP: begin
                  state_r <= ST_IDLE;
                  if (bit_s && odd_parity_ok(shift_r, parity_r)) begin
                     code_r       <= shift_r;
                     code_valid_r <= 1'b1;
                     disp_en_r    <= 1'b1;
                     if (shift_r == BREAK_CODE) begin
                        break_r <= 1'b1;
                     end else if (shift_r == EXT_CODE) begin
                        break_r <= break_r;
                     end else if (break_r) begin
                        break_r <= 1'b0;
                        if (shift_r == key_code_r) begin
                           key_down_r <= 1'b0;
                        end
                     end else if (!(key_down_r && shift_r == key_code_r)) begin
                        // Anything other than a typematic repeat of the held key is a new press.
                        key_code_r  <= shift_r;
                        key_down_r  <= 1'b1;
                        press_cnt_r <= press_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                     end
                  end else begin
                     frame_err_r <= 1'b1;
                  end
               end
               default: state_r <= ST_IDLE;
            endcase
         end else if (tmo_cnt_r == TMO_LAST) begin
            frame_err_r <= 1'b1;
            state_r     <= ST_IDLE;
            tmo_cnt_r   <= '0;
         end else begin
            tmo_cnt_r <= tmo_cnt_r + {{(TW-1){1'b0}}, 1'b1};
         end
      end
   end

   assign code       = code_r;
   assign code_valid = code_valid_r;
   assign frame_err  = frame_err_r;
   assign key_code   = key_code_r;
   assign key_down   = key_down_r;
   assign press_cnt  = press_cnt_r;

   seg7_hex u_seg_lo (.value(code_r[3:0]), .en(disp_en_r), .seg(seg_lo));
   seg7_hex u_seg_hi (.value(code_r[7:4]), .en(disp_en_r), .seg(seg_hi));

endmodule

// File: tb/tb_ps2_keyboard.sv
// Directed self-checking bench for ps2_keyboard: good/bad frames, make/break,
// timeout, mid-frame reset and press counter wrap.
module tb_ps2_keyboard;

   localparam int TMO  = 200;
   localparam int CW   = 8;
   localparam int HALF = 4;

   logic          clk;
   logic          resetn;
   logic          ps2_clk;
   logic          ps2_data;
   logic [7:0]    code;
   logic          code_valid;
   logic          frame_err;
   logic [7:0]    key_code;
   logic          key_down;
   logic [CW-1:0] press_cnt;
   logic [6:0]    seg_lo;
   logic [6:0]    seg_hi;

   int n_checks = 0;
   int n_pass   = 0;
   int n_valid  = 0;
   int n_err    = 0;
   int v0;
   int e0;

   ps2_keyboard #(.TIMEOUT_CYCLES(TMO), .CNT_W(CW)) dut (
      .clk        (clk),
      .resetn     (resetn),
      .ps2_clk    (ps2_clk),
      .ps2_data   (ps2_data),
      .code       (code),
      .code_valid (code_valid),
      .frame_err  (frame_err),
      .key_code   (key_code),
      .key_down   (key_down),
      .press_cnt  (press_cnt),
      .seg_lo     (seg_lo),
      .seg_hi     (seg_hi)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Count strobe cycles so pulse count and width can both be checked.
   always @(negedge clk) begin
      if (code_valid) n_valid++;
      if (frame_err)  n_err++;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: sim time limit reached, checks=%0d", n_checks);
      $fatal(1);
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(posedge clk);
   endtask

   // Send the first nbits of a frame; optionally corrupt parity or stop bit.
   task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic bad_stop,
                             input int nbits);
      logic [10:0] fr;
      fr = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
      for (int i = 0; i < nbits; i++) begin
         ps2_data = fr[i];
         wait_clk(HALF);
         ps2_clk = 1'b0;
         wait_clk(HALF);
         ps2_clk = 1'b1;
      end
      ps2_data = 1'b1;
      wait_clk(6);
      @(negedge clk);
   endtask

   task automatic send_byte(input logic [7:0] b);
      send_frame(b, 1'b0, 1'b0, 11);
   endtask

   initial begin
      resetn   = 1'b0;
      ps2_clk  = 1'b1;
      ps2_data = 1'b1;
      wait_clk(3);
      @(negedge clk);
      resetn = 1'b1;
      wait_clk(2);
      @(negedge clk);

      check_eq("rst_code", code, 8'h00);
      check_eq("rst_valid", code_valid, 1'b0);
      check_eq("rst_err", frame_err, 1'b0);
      check_eq("rst_key_code", key_code, 8'h00);
      check_eq("rst_key_down", key_down, 1'b0);
      check_eq("rst_cnt", press_cnt, 8'd0);
      check_eq("rst_seg_lo", seg_lo, 7'h7F);
      check_eq("rst_seg_hi", seg_hi, 7'h7F);

      // Lone falling edge with data high while idle is ignored silently.
      v0 = n_valid; e0 = n_err;
      send_frame(8'hFF, 1'b0, 1'b1, 0);
      ps2_data = 1'b1;
      wait_clk(HALF);
      ps2_clk = 1'b0;
      wait_clk(HALF);
      ps2_clk = 1'b1;
      wait_clk(6);
      check_eq("idle_hi_err", n_err - e0, 0);
      check_eq("idle_hi_valid", n_valid - v0, 0);

      v0 = n_valid;
      send_byte(8'h1C);
      check_eq("t1_valid_cycles", n_valid - v0, 1);
      check_eq("t1_code", code, 8'h1C);
      check_eq("t1_seg_lo", seg_lo, 7'h46);
      check_eq("t1_seg_hi", seg_hi, 7'h79);
      check_eq("t1_key_down", key_down, 1'b1);
      check_eq("t1_key_code", key_code, 8'h1C);
      check_eq("t1_cnt", press_cnt, 8'd1);

      send_byte(8'h1C);
      check_eq("t2_repeat_cnt", press_cnt, 8'd1);
      send_byte(8'hF0);
      check_eq("t2_break_code", code, 8'hF0);
      check_eq("t2_break_down", key_down, 1'b1);
      send_byte(8'h1C);
      check_eq("t2_up_down", key_down, 1'b0);
      check_eq("t2_up_key", key_code, 8'h1C);
      check_eq("t2_up_cnt", press_cnt, 8'd1);

      v0 = n_valid; e0 = n_err;
      send_frame(8'h1C, 1'b1, 1'b0, 11);
      check_eq("t3_par_err", n_err - e0, 1);
      check_eq("t3_par_valid", n_valid - v0, 0);
      check_eq("t3_par_code", code, 8'h1C);
      e0 = n_err;
      send_frame(8'h33, 1'b0, 1'b1, 11);
      check_eq("t3_stop_err", n_err - e0, 1);
      check_eq("t3_stop_code", code, 8'h1C);
      send_byte(8'h16);
      check_eq("t3_code", code, 8'h16);
      check_eq("t3_seg_lo", seg_lo, 7'h02);
      check_eq("t3_seg_hi", seg_hi, 7'h79);
      check_eq("t3_cnt", press_cnt, 8'd2);

      v0 = n_valid; e0 = n_err;
      send_frame(8'hA5, 1'b0, 1'b0, 6);
      wait_clk(TMO / 2);
      check_eq("t4_no_early_err", n_err - e0, 0);
      wait_clk(TMO);
      check_eq("t4_tmo_err", n_err - e0, 1);
      check_eq("t4_tmo_valid", n_valid - v0, 0);
      send_byte(8'h45);
      check_eq("t4_code", code, 8'h45);
      check_eq("t4_seg_lo", seg_lo, 7'h12);
      check_eq("t4_seg_hi", seg_hi, 7'h19);
      check_eq("t4_cnt", press_cnt, 8'd3);

      send_byte(8'h1C);
      send_frame(8'h2B, 1'b0, 1'b0, 4);
      #3 resetn = 1'b0;
      #3;
      check_eq("t5_rst_code", code, 8'h00);
      check_eq("t5_rst_key", key_code, 8'h00);
      check_eq("t5_rst_down", key_down, 1'b0);
      check_eq("t5_rst_cnt", press_cnt, 8'd0);
      check_eq("t5_rst_seg_lo", seg_lo, 7'h7F);
      check_eq("t5_rst_seg_hi", seg_hi, 7'h7F);
      wait_clk(3);
      @(negedge clk);
      resetn = 1'b1;
      wait_clk(2);
      send_byte(8'h1E);
      check_eq("t5_code", code, 8'h1E);
      check_eq("t5_cnt", press_cnt, 8'd1);
      check_eq("t5_seg_lo", seg_lo, 7'h06);

      resetn = 1'b0;
      wait_clk(2);
      @(negedge clk);
      resetn = 1'b1;
      wait_clk(2);
      send_byte(8'h16);
      send_byte(8'h1E);
      check_eq("t6_key", key_code, 8'h1E);
      check_eq("t6_cnt", press_cnt, 8'd2);
      for (int i = 0; i < 254; i++) begin
         send_byte((i % 2 == 0) ? 8'h16 : 8'h1E);
      end
      check_eq("t6_wrap_cnt", press_cnt, 8'd0);
      check_eq("t6_wrap_key", key_code, 8'h1E);
      check_eq("t6_wrap_down", key_down, 1'b1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
